// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and stall/flush controls back to the pipeline registers.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       branch_taken_d;
  logic       div_start_e;
  logic       dmem_req_m;
  logic       dmem_ack;
  logic       exc_m;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic       flush_w;
  logic       exc_redirect;
  logic       busy;

  // Datapath side: reports hazards, obeys stall/flush.
  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, branch_taken_d, div_start_e,
    output dmem_req_m, dmem_ack, exc_m,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w, exc_redirect, busy
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, branch_taken_d, div_start_e,
    input  dmem_req_m, dmem_ack, exc_m,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w, exc_redirect, busy
  );

endinterface

// File: rtl/pipeline_ctrl_div_counter.sv
// Loadable down-counter tracking the remaining hold cycles of a multi-cycle divide.
module div_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: resolves exception, memory wait, divide, load-use and
// taken-branch hazards for the 5-stage pipeline.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave pipe
);

  localparam bit               DIV_EN   = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  pipe_state_t      r_state;
  pipe_state_t      w_state_d;

  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_value;
  logic             w_cnt_zero;

  logic             w_load_use;
  logic             w_mem_miss;

  logic w_sf, w_sd, w_se, w_sm;
  logic w_fd, w_fe, w_fm, w_fw;
  logic w_exr, w_busy;

  div_counter u_div_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (DIV_LOAD),
    .i_dec      (w_cnt_dec && (w_cnt_value != '0)),
    .o_value    (w_cnt_value),
    .o_zero     (w_cnt_zero)
  );

  assign w_load_use = pipe.ex_memread && (pipe.ex_rt != REG_ZERO) &&
                      ((pipe.ex_rt == pipe.id_rs) || (pipe.ex_rt == pipe.id_rt));
  assign w_mem_miss = pipe.dmem_req_m && !pipe.dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_sf = 1'b0; w_sd = 1'b0; w_se = 1'b0; w_sm = 1'b0;
    w_fd = 1'b0; w_fe = 1'b0; w_fm = 1'b0; w_fw = 1'b0;
    w_exr  = 1'b0;
    w_busy = (r_state != RUN);

    unique case (r_state)
      RUN: begin
        if (pipe.exc_m) begin
          {w_fd, w_fe, w_fm, w_fw, w_exr} = '1;
        end else if (w_mem_miss) begin
          {w_sf, w_sd, w_se, w_sm, w_fw} = '1;
          w_state_d = MEM_WAIT;
        end else if (pipe.div_start_e && DIV_EN) begin
          {w_sf, w_sd, w_se, w_fm} = '1;
          w_cnt_load = 1'b1;
          w_state_d  = DIV_WAIT;
        end else if (w_load_use) begin
          {w_sf, w_sd, w_fe} = '1;
        end else if (pipe.branch_taken_d) begin
          w_fd = 1'b1;
        end
      end

      DIV_WAIT: begin
        if (pipe.exc_m) begin
          {w_fd, w_fe, w_fm, w_fw, w_exr} = '1;
          w_state_d = RUN;
        end else if (!w_cnt_zero) begin
          {w_sf, w_sd, w_se, w_fm} = '1;
          w_cnt_dec = 1'b1;
        end else begin
          // Last divide cycle: the divide itself leaves EX, so div_start_e is stale.
          w_state_d = RUN;
        end
      end

      MEM_WAIT: begin
        if (!pipe.dmem_ack) begin
          {w_sf, w_sd, w_se, w_sm, w_fw} = '1;
        end else begin
          w_state_d = RUN;
        end
      end

      default: begin
        w_state_d = RUN;
      end
    endcase

    if (rst) begin
      w_sf = 1'b0; w_sd = 1'b0; w_se = 1'b0; w_sm = 1'b0;
      w_fd = 1'b0; w_fe = 1'b0; w_fm = 1'b0; w_fw = 1'b0;
      w_exr  = 1'b0;
      w_busy = 1'b0;
    end
  end

  assign pipe.stall_f      = w_sf;
  assign pipe.stall_d      = w_sd;
  assign pipe.stall_e      = w_se;
  assign pipe.stall_m      = w_sm;
  assign pipe.flush_d      = w_fd;
  assign pipe.flush_e      = w_fe;
  assign pipe.flush_m      = w_fm;
  assign pipe.flush_w      = w_fw;
  assign pipe.exc_redirect = w_exr;
  assign pipe.busy         = w_busy;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard rows, multi-cycle holds, priority and reset.
module tb_pipeline_ctrl;

  localparam logic [9:0] O_SF = 10'h200, O_SD = 10'h100, O_SE = 10'h080, O_SM = 10'h040;
  localparam logic [9:0] O_FD = 10'h020, O_FE = 10'h010, O_FM = 10'h008, O_FW = 10'h004;
  localparam logic [9:0] O_EX = 10'h002, O_BZ = 10'h001;
  localparam logic [9:0] DIV_ST = O_SF | O_SD | O_SE | O_FM;
  localparam logic [9:0] MEM_ST = O_SF | O_SD | O_SE | O_SM | O_FW;
  localparam logic [9:0] EXC    = O_FD | O_FE | O_FM | O_FW | O_EX;
  localparam logic [9:0] LU     = O_SF | O_SD | O_FE;

  typedef struct packed {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic [9:0] exp;
  } lu_vec_t;

  typedef struct packed {
    logic       req;
    logic       ack;
    logic       div;
    logic       br;
    logic       exc;
    logic [9:0] exp;
  } ev_vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [9:0] got;

  pipeline_ctrl_if u_if ();
  pipeline_ctrl_if u_if1 ();

  pipeline_ctrl #(.DIV_CYCLES(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (u_if.slave)
  );

  pipeline_ctrl #(.DIV_CYCLES(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .pipe (u_if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] outs0();
    return {u_if.stall_f, u_if.stall_d, u_if.stall_e, u_if.stall_m, u_if.flush_d,
            u_if.flush_e, u_if.flush_m, u_if.flush_w, u_if.exc_redirect, u_if.busy};
  endfunction

  function automatic logic [9:0] outs1();
    return {u_if1.stall_f, u_if1.stall_d, u_if1.stall_e, u_if1.stall_m, u_if1.flush_d,
            u_if1.flush_e, u_if1.flush_m, u_if1.flush_w, u_if1.exc_redirect, u_if1.busy};
  endfunction

  task automatic clear_inputs();
    u_if.id_rs = '0; u_if.id_rt = '0; u_if.ex_memread = 1'b0; u_if.ex_rt = '0;
    u_if.branch_taken_d = 1'b0; u_if.div_start_e = 1'b0; u_if.dmem_req_m = 1'b0;
    u_if.dmem_ack = 1'b0; u_if.exc_m = 1'b0;
    u_if1.id_rs = '0; u_if1.id_rt = '0; u_if1.ex_memread = 1'b0; u_if1.ex_rt = '0;
    u_if1.branch_taken_d = 1'b0; u_if1.div_start_e = 1'b0; u_if1.dmem_req_m = 1'b0;
    u_if1.dmem_ack = 1'b0; u_if1.exc_m = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ev(input ev_vec_t v);
    u_if.dmem_req_m = v.req; u_if.dmem_ack = v.ack; u_if.div_start_e = v.div;
    u_if.branch_taken_d = v.br; u_if.exc_m = v.exc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.exc_m = 1'b1; u_if.dmem_req_m = 1'b1; u_if.div_start_e = 1'b1;
    u_if.branch_taken_d = 1'b1;
    #2;
    got = outs0(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL reset_hold: got %b expected %b", got, 10'h000);
    end
    cyc(); cyc();
    got = outs0(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL reset_hold_clk: got %b expected %b", got, 10'h000);
    end
    rst = 1'b0;
    clear_inputs();
    #2;
    got = outs0(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL reset_idle: got %b expected %b", got, 10'h000);
    end
  endtask

  task automatic test_load_use();
    lu_vec_t v [8];
    v = '{'{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, LU},
          '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'h000},
          '{1'b1, 5'd9, 5'd3, 5'd9, 1'b0, LU},
          '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 10'h000},
          '{1'b1, 5'd8, 5'd7, 5'd6, 1'b0, 10'h000},
          '{1'b0, 5'd8, 5'd8, 5'd0, 1'b1, O_FD},
          '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, LU},
          '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 10'h000}};
    for (int i = 0; i < 8; i++) begin
      cyc();
      u_if.ex_memread = v[i].mr; u_if.ex_rt = v[i].ert; u_if.id_rs = v[i].rs;
      u_if.id_rt = v[i].rt; u_if.branch_taken_d = v[i].br;
      #2;
      got = outs0(); n_vec++;
      if (got !== v[i].exp) begin
        n_err++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, v[i].exp);
      end
    end
  endtask

  task automatic test_divide();
    logic       div [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0] exp [5] = '{DIV_ST, DIV_ST | O_BZ, DIV_ST | O_BZ, O_BZ, 10'h000};
    for (int i = 0; i < 5; i++) begin
      cyc();
      u_if.div_start_e = div[i];
      #2;
      got = outs0(); n_vec++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL divide[%0d]: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    ev_vec_t v [7];
    v = '{'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MEM_ST},
          '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MEM_ST | O_BZ},
          '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MEM_ST | O_BZ},
          '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BZ},
          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000},
          '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000},
          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000}};
    for (int i = 0; i < 7; i++) begin
      cyc();
      apply_ev(v[i]);
      #2;
      got = outs0(); n_vec++;
      if (got !== v[i].exp) begin
        n_err++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, got, v[i].exp);
      end
    end
  endtask

  task automatic test_exception();
    ev_vec_t v [5];
    v = '{'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DIV_ST},
          '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, EXC | O_BZ},
          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000},
          '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, EXC},
          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000}};
    for (int i = 0; i < 5; i++) begin
      cyc();
      apply_ev(v[i]);
      #2;
      got = outs0(); n_vec++;
      if (got !== v[i].exp) begin
        n_err++; $display("FAIL exception[%0d]: got %b expected %b", i, got, v[i].exp);
      end
    end
  endtask

  task automatic test_priority();
    ev_vec_t v [8];
    v = '{'{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, MEM_ST},
          '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, MEM_ST | O_BZ},
          '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_BZ},
          '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DIV_ST},
          '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DIV_ST | O_BZ},
          '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DIV_ST | O_BZ},
          '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BZ},
          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000}};
    for (int i = 0; i < 8; i++) begin
      cyc();
      apply_ev(v[i]);
      #2;
      got = outs0(); n_vec++;
      if (got !== v[i].exp) begin
        n_err++; $display("FAIL priority[%0d]: got %b expected %b", i, got, v[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] exp [4] = '{DIV_ST | O_BZ, DIV_ST | O_BZ, O_BZ, 10'h000};
    cyc();
    u_if.dmem_req_m = 1'b1;
    cyc();
    got = outs0(); n_vec++;
    if (got !== (MEM_ST | O_BZ)) begin
      n_err++; $display("FAIL arst_pre: got %b expected %b", got, MEM_ST | O_BZ);
    end
    #2 rst = 1'b1;
    #1;
    got = outs0(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL arst_mem_outputs: got %b expected %b", got, 10'h000);
    end
    cyc();
    rst = 1'b0;
    #2;
    got = outs0(); n_vec++;
    if (got !== MEM_ST) begin
      n_err++; $display("FAIL arst_mem_run: got %b expected %b", got, MEM_ST);
    end
    cyc();
    u_if.dmem_ack = 1'b1;
    #2;
    got = outs0(); n_vec++;
    if (got !== O_BZ) begin
      n_err++; $display("FAIL arst_mem_ack: got %b expected %b", got, O_BZ);
    end
    cyc();
    clear_inputs();
    u_if.div_start_e = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    got = outs0(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL arst_div_outputs: got %b expected %b", got, 10'h000);
    end
    cyc();
    rst = 1'b0;
    #2;
    got = outs0(); n_vec++;
    if (got !== DIV_ST) begin
      n_err++; $display("FAIL arst_div_restart: got %b expected %b", got, DIV_ST);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) u_if.div_start_e = 1'b0;
      #2;
      got = outs0(); n_vec++;
      if (got !== exp[i]) begin
        n_err++; $display("FAIL arst_div_seq[%0d]: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_div_single();
    cyc();
    u_if1.div_start_e = 1'b1;
    #2;
    got = outs1(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL div1_ignored: got %b expected %b", got, 10'h000);
    end
    cyc();
    u_if1.ex_memread = 1'b1; u_if1.ex_rt = 5'd12; u_if1.id_rt = 5'd12;
    #2;
    got = outs1(); n_vec++;
    if (got !== LU) begin
      n_err++; $display("FAIL div1_load_use: got %b expected %b", got, LU);
    end
    cyc();
    clear_inputs();
    #2;
    got = outs1(); n_vec++;
    if (got !== 10'h000) begin
      n_err++; $display("FAIL div1_idle: got %b expected %b", got, 10'h000);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_exception();
    test_priority();
    test_async_reset();
    test_div_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the `stall` (hold) and `clear` (bubble) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. It resolves five hazard classes: load-use, taken branch, multi-cycle divide, data-memory wait, and MEM-stage exception. A small FSM plus a divide counter holds the pipeline across multi-cycle events.

## Interface
Parameters:
- DIV_CYCLES, 4, cycles a divide occupies EX (1..64)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination of the load in EX
- branch_taken_d  in  1  branch resolved taken in ID
- div_start_e  in  1  divide instruction present in EX
- dmem_req_m  in  1  MEM-stage memory access outstanding
- dmem_ack  in  1  data memory completes this cycle
- exc_m  in  1  instruction in MEM raises an exception
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flush_d, flush_e, flush_m, flush_w  out  1 each  clear IF-ID / ID-EX / EX-MEM / MEM-WB
- exc_redirect  out  1  load exception vector into PC
- busy  out  1  FSM not in RUN

## Operation
- States: RUN, DIV_WAIT, MEM_WAIT. Reset state is RUN; the divide counter resets to 0.
- While rst is high, all outputs are 0.
- Outputs are combinational from state and inputs. Only state and counter are registered.

Priority in RUN, highest first; only the winning row drives outputs:
1. **exc_m**
   - Outputs: flush_d, flush_e, flush_m, flush_w, exc_redirect.
   - Next state: RUN.
2. **dmem_req_m & !dmem_ack**
   - Outputs: stall_f, stall_d, stall_e, stall_m, flush_w.
   - Next state: MEM_WAIT.
3. **div_start_e, DIV_CYCLES > 1**
   - Outputs: stall_f, stall_d, stall_e, flush_m.
   - Action: load cnt = DIV_CYCLES-2.
   - Next state: DIV_WAIT.
   - If DIV_CYCLES = 1, div_start_e is ignored.
4. **Load-use:** ex_memread & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt)
   - Outputs: stall_f, stall_d, flush_e.
5. **branch_taken_d**
   - Output: flush_d.
   - Never combined with stall_d.

DIV_WAIT:
- exc_m: same as RUN row 1; the divide is aborted and the next state is RUN.
- cnt != 0: stall_f/d/e and flush_m; decrement cnt.
- cnt == 0: no stall; next state RUN. div_start_e is ignored this cycle because it is the same divide leaving EX.

MEM_WAIT:
- !dmem_ack: stall_f/d/e/m and flush_w.
- dmem_ack: no stall; next state RUN.
- exc_m is ignored in MEM_WAIT; the MEM stage never raises an exception with a request outstanding.

Other rules:
- busy = (state != RUN).
- A divide deferred by a memory wait stays in EX (held by stall_e). It restarts via row 3 on return to RUN.

## Timing
- Divide starting in cycle N holds the pipeline for cycles N..N+DIV_CYCLES-2 (DIV_CYCLES-1 stall cycles). The divide enters EX/MEM at the end of cycle N+DIV_CYCLES-1.
- Memory miss starting in cycle N with ack in cycle N+k: stalls cycles N..N+k-1; the pipeline advances at the end of N+k.
- Memory ack arriving in the same cycle as the request: zero stall, no state change.
- Load-use: exactly 1 bubble per occurrence; no state change.
- Exception: single cycle. The handler fetch begins in cycle N+1.
- Reset mid-DIV_WAIT or MEM_WAIT: return to RUN immediately and clear cnt.

## Structure
- Package pipeline_ctrl_pkg: `pipe_state_t` enum (RUN, DIV_WAIT, MEM_WAIT) and `REG_ZERO` constant (5'd0).
- Sub-module div_counter: loadable 6-bit down-counter with `load`, `value` and `zero` outputs.
- Remainder: state register plus one combinational output block.

## Test plan
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle → stall_f=stall_d=flush_e=1 that cycle only. With ex_rt=0: no stall.
- Divide, DIV_CYCLES=4, div_start_e held from cycle 10 → stall_f/d/e and flush_m high in cycles 10–12, low in 13, busy high in 11–13, state RUN in 14.
- Memory wait: dmem_req_m from cycle 5, dmem_ack at cycle 8 → stall_f..stall_m and flush_w high in 5–7, all low in 8. Ack in cycle 5 → no stall.
- Exception during DIV_WAIT (cycle 11) → flush_d/e/m/w and exc_redirect high in 11, no stalls, RUN in 12.
- Priority: dmem miss with div_start_e and branch_taken_d all in cycle 20 → memory stall only, flush_d=0. After ack, divide sequence starts.
- Async reset asserted mid-MEM_WAIT → all outputs 0 immediately; RUN after release.
